// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified-memory port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, I_ACC, D_ACC)
//   SEL_FETCH / SEL_DATA : address-mux select codes (A = PC, B = ALU address)
//   FETCH / DATA : grant identifiers, also used by the round-robin history
//   is_acc()      : true when a state owns the memory port
//   grant_state() : maps a grant identifier to its access state
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2
  } arb_state_e;

  localparam logic SEL_FETCH = 1'b0;
  localparam logic SEL_DATA  = 1'b1;

  localparam logic FETCH = 1'b0;
  localparam logic DATA  = 1'b1;

  function automatic logic is_acc(input arb_state_e s);
    return (s == I_ACC) || (s == D_ACC);
  endfunction

  function automatic arb_state_e grant_state(input logic id);
    return (id == DATA) ? D_ACC : I_ACC;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Handshake bundle between the requesters/memory and the port arbiter.
//   Requester/memory side drives : if_req, d_req, d_we, mem_ready
//   Arbiter drives               : addr_sel, mem_req, mem_we, if_ack, d_ack,
//                                  bus_err, if_stall, busy
// Modports: master = requester/memory side, slave = arbiter.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic if_req;
  logic d_req;
  logic d_we;
  logic mem_ready;
  logic addr_sel;
  logic mem_req;
  logic mem_we;
  logic if_ack;
  logic d_ack;
  logic bus_err;
  logic if_stall;
  logic busy;

  modport master (
    output if_req, d_req, d_we, mem_ready,
    input  addr_sel, mem_req, mem_we, if_ack, d_ack, bus_err, if_stall, busy
  );

  modport slave (
    input  if_req, d_req, d_we, mem_ready,
    output addr_sel, mem_req, mem_we, if_ack, d_ack, bus_err, if_stall, busy
  );

endinterface

// File: rtl/arb_timeout_ctr.sv
// ---------------------------------------------------------------------------
// arb_timeout_ctr
// Wait-cycle counter for a memory access. Cleared at every grant, counts each
// access cycle in which memory is not ready; expired flags the last allowed
// wait cycle (count == TIMEOUT_CYCLES-1).
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   clear   in  restart the count from zero (has priority over enable)
//   enable  in  count one wait cycle
//   expired out count has reached TIMEOUT_CYCLES-1
// Parameters: TIMEOUT_CYCLES (2..255), CNT_W with 2^CNT_W > TIMEOUT_CYCLES.
// ---------------------------------------------------------------------------
module arb_timeout_ctr
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_r;

  // wait-cycle counter with clear priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Arbitrates the single-ported unified memory between instruction fetch and
// the data (load/store) stage, steers the address mux, sequences
// variable-latency accesses on a request/ready handshake and aborts accesses
// that wait too long.
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of mem_port_arbiter_if:
//            in : if_req, d_req, d_we, mem_ready
//            out: addr_sel (0 fetch/1 data), mem_req, mem_we, if_ack, d_ack,
//                 bus_err, if_stall, busy
// Build option: define ARB_ROUND_ROBIN_EN to replace fixed data priority on
// simultaneous requests with round-robin (first tie after reset goes to
// fetch). Without it data always wins a tie.
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  arb_state_e state_r;
  arb_state_e next_state_s;
  logic       addr_sel_r;
  logic       mem_req_r;
  logic       we_r;
  logic       busy_r;
  logic       expired_s;
  logic       in_acc_s;
  logic       done_s;
  logic       timeout_s;
  logic       grant_s;
  logic       if_ack_s;
  logic       d_ack_s;
`ifdef ARB_ROUND_ROBIN_EN
  logic       last_grant_r;
`endif

  assign in_acc_s  = is_acc(state_r);
  // mem_ready beats a coincident timeout, so bus_err needs ready low
  assign timeout_s = in_acc_s & expired_s & ~bus.mem_ready;
  assign done_s    = in_acc_s & (bus.mem_ready | expired_s);
  // a grant happens whenever the next state owns the port and the current
  // access (if any) finishes this cycle
  assign grant_s   = is_acc(next_state_s) & (~in_acc_s | done_s);

  arb_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (~in_acc_s | done_s),
    .enable  (in_acc_s & ~bus.mem_ready),
    .expired (expired_s)
  );

  // next-state decode: idle arbitration and hand-over on completion
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (bus.d_req && bus.if_req) begin
          next_state_s = grant_state((last_grant_r == DATA) ? FETCH : DATA);
        end else if (bus.d_req || bus.if_req) begin
          next_state_s = grant_state(bus.d_req ? DATA : FETCH);
        end else begin
          next_state_s = IDLE;
        end
`else
        if (bus.d_req || bus.if_req) begin
          next_state_s = grant_state(bus.d_req ? DATA : FETCH);
        end else begin
          next_state_s = IDLE;
        end
`endif
      end
      I_ACC: begin
        // completing owner's own request is ignored; only data may follow
        if (bus.mem_ready) begin
          next_state_s = bus.d_req ? D_ACC : IDLE;
        end else if (expired_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = I_ACC;
        end
      end
      D_ACC: begin
        if (bus.mem_ready) begin
          next_state_s = bus.if_req ? I_ACC : IDLE;
        end else if (expired_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = D_ACC;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // FSM state and registered port-control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      addr_sel_r   <= SEL_FETCH;
      mem_req_r    <= 1'b0;
      we_r         <= 1'b0;
      busy_r       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_r <= DATA;
`endif
    end else begin
      state_r   <= next_state_s;
      mem_req_r <= is_acc(next_state_s);
      busy_r    <= (next_state_s != IDLE);
      case (next_state_s)
        D_ACC: begin
          addr_sel_r <= SEL_DATA;
          // write enable is captured once at grant and held for the access
          we_r       <= grant_s ? bus.d_we : we_r;
        end
        I_ACC: begin
          addr_sel_r <= SEL_FETCH;
          we_r       <= 1'b0;
        end
        default: begin
          // mux select holds its last value while idle
          addr_sel_r <= addr_sel_r;
          we_r       <= 1'b0;
        end
      endcase
`ifdef ARB_ROUND_ROBIN_EN
      if (grant_s) begin
        last_grant_r <= (next_state_s == D_ACC) ? DATA : FETCH;
      end else begin
        last_grant_r <= last_grant_r;
      end
`endif
    end
  end

  assign if_ack_s     = (state_r == I_ACC) & done_s;
  assign d_ack_s      = (state_r == D_ACC) & done_s;

  assign bus.addr_sel = addr_sel_r;
  assign bus.mem_req  = mem_req_r;
  assign bus.mem_we   = we_r;
  assign bus.busy     = busy_r;
  assign bus.if_ack   = if_ack_s;
  assign bus.d_ack    = d_ack_s;
  assign bus.bus_err  = timeout_s;
  assign bus.if_stall = bus.if_req & ~if_ack_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed stimulus with a scoreboard: each stimulus step queues the ack it
// expects (owner, bus_err, mem_we, addr_sel, cycle); a negedge monitor pops
// and compares whenever the arbiter pulses an ack.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  typedef struct {
    bit is_d;
    bit err;
    bit we;
    bit sel;
    int at;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errs = 0;
  int   d_seen = 0;
  int   i_seen = 0;
  exp_t q[$];

  mem_port_arbiter_if bus();

  mem_port_arbiter #(
    .TIMEOUT_CYCLES (16),
    .CNT_W          (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ack(input bit is_d, input bit err, input bit we, input bit sel, input int at);
    exp_t e;
    e.is_d = is_d; e.err = err; e.we = we; e.sel = sel; e.at = at;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 40 && q.size() != 0; k++) step();
    chk(name, q.size(), 0);
  endtask

  // scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (bus.if_ack === 1'b1 || bus.d_ack === 1'b1) begin
          n_checks++;
          if (q.size() == 0) begin
            n_errs++;
            $display("FAIL unexpected_ack: if_ack=%b d_ack=%b bus_err=%b at cycle %0d, none expected",
                     bus.if_ack, bus.d_ack, bus.bus_err, cyc);
          end else begin
            e = q.pop_front();
            if ({bus.if_ack, bus.d_ack, bus.bus_err, bus.mem_we, bus.addr_sel} !==
                {~e.is_d, e.is_d, e.err, e.we, e.sel} || cyc != e.at) begin
              n_errs++;
              $display("FAIL ack_compare: got if_ack=%b d_ack=%b err=%b we=%b sel=%b cycle=%0d, expected if_ack=%b d_ack=%b err=%b we=%b sel=%b cycle=%0d",
                       bus.if_ack, bus.d_ack, bus.bus_err, bus.mem_we, bus.addr_sel, cyc,
                       ~e.is_d, e.is_d, e.err, e.we, e.sel, e.at);
            end
          end
          if (bus.d_ack === 1'b1) d_seen++;
          else i_seen++;
        end else if (bus.bus_err !== 1'b0) begin
          n_checks++;
          n_errs++;
          $display("FAIL err_without_ack: bus_err=%b at cycle %0d, expected 0", bus.bus_err, cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by time %0t, expected earlier finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int d0;
    int i0;
    bit first_d;
    bit is_d;
    bus.if_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0; bus.mem_ready = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif

    // reset state
    #3;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_addr_sel", bus.addr_sel, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_acks", {bus.if_ack, bus.d_ack, bus.bus_err}, 0);
    #19 rst_n = 1'b1;

    // fetch with three wait cycles
    step(); n = cyc; bus.if_req = 1'b1; expect_ack(1'b0, 1'b0, 1'b0, 1'b0, n + 4);
    #3 chk("t1_req_c0", bus.mem_req, 0); chk("t1_stall_c0", bus.if_stall, 1);
    step(); #3 chk("t1_req_c1", bus.mem_req, 1); chk("t1_sel_c1", bus.addr_sel, 0);
    chk("t1_busy_c1", bus.busy, 1); chk("t1_stall_c1", bus.if_stall, 1);
    step(); step(); #3 chk("t1_stall_c3", bus.if_stall, 1);
    step(); bus.mem_ready = 1'b1; #3 chk("t1_stall_c4", bus.if_stall, 0);
    step(); bus.mem_ready = 1'b0; bus.if_req = 1'b0;
    #3 chk("t1_idle_busy", bus.busy, 0); chk("t1_idle_req", bus.mem_req, 0);
    drain("t1_drain");

    // mem_ready while idle produces no ack
    step(); bus.mem_ready = 1'b1; step(); step(); bus.mem_ready = 1'b0;
    #3 chk("idle_ready_busy", bus.busy, 0);

    // simultaneous requests, memory always ready: back-to-back grants
    step(); n = cyc;
    bus.if_req = 1'b1; bus.d_req = 1'b1; bus.d_we = 1'b1; bus.mem_ready = 1'b1;
    expect_ack(first_d, 1'b0, first_d, first_d, n + 1);
    expect_ack(~first_d, 1'b0, ~first_d, ~first_d, n + 2);
    step(); #3 chk("t2_busy_c1", bus.busy, 1);
    step();
    if (first_d) bus.d_req = 1'b0;
    else bus.if_req = 1'b0;
    #3 chk("t2_no_gap", bus.mem_req, 1);
    step(); bus.if_req = 1'b0; bus.d_req = 1'b0; bus.mem_ready = 1'b0; bus.d_we = 1'b0;
    #3 chk("t2_idle", bus.busy, 0);
    drain("t2_drain");

    // timeout on the 16th wait cycle
    step(); n = cyc; bus.d_req = 1'b1; bus.d_we = 1'b0;
    expect_ack(1'b1, 1'b1, 1'b0, 1'b1, n + 16);
    repeat (16) step();
    step(); bus.d_req = 1'b0; #3 chk("t3_idle", bus.busy, 0);
    drain("t3_drain");

    // ready arriving on the timeout cycle wins
    step(); n = cyc; bus.d_req = 1'b1;
    expect_ack(1'b1, 1'b0, 1'b0, 1'b1, n + 16);
    repeat (16) step();
    bus.mem_ready = 1'b1;
    step(); bus.mem_ready = 1'b0; bus.d_req = 1'b0; #3 chk("t3b_idle", bus.busy, 0);
    drain("t3b_drain");

    // d_we changes after grant are ignored
    step(); n = cyc; bus.d_req = 1'b1; bus.d_we = 1'b1;
    expect_ack(1'b1, 1'b0, 1'b1, 1'b1, n + 3);
    step(); bus.d_we = 1'b0; #3 chk("t4_we_c1", bus.mem_we, 1);
    step(); #3 chk("t4_we_c2", bus.mem_we, 1);
    step(); bus.mem_ready = 1'b1;
    step(); bus.mem_ready = 1'b0; bus.d_req = 1'b0; #3 chk("t4_we_after", bus.mem_we, 0);
    drain("t4_drain");

    // asynchronous reset in the middle of a data access
    step(); bus.d_req = 1'b1; bus.d_we = 1'b1;
    step(); step(); #3 chk("t5_pre_req", bus.mem_req, 1);
    #2 rst_n = 1'b0;
    #1 chk("t5_rst_req", bus.mem_req, 0); chk("t5_rst_we", bus.mem_we, 0);
    chk("t5_rst_busy", bus.busy, 0); chk("t5_rst_dack", bus.d_ack, 0);
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    step(); step(); rst_n = 1'b1; n = cyc; bus.if_req = 1'b1;
    expect_ack(1'b0, 1'b0, 1'b0, 1'b0, n + 2);
    step(); #3 chk("t5_i_sel", bus.addr_sel, 0); chk("t5_i_req", bus.mem_req, 1);
    chk("t5_i_we", bus.mem_we, 0);
    step(); bus.mem_ready = 1'b1;
    step(); bus.mem_ready = 1'b0; bus.if_req = 1'b0;
    drain("t5_drain");

    // continuous contention for 20 accesses
    step(); n = cyc; d0 = d_seen; i0 = i_seen;
    bus.if_req = 1'b1; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.mem_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      is_d = ((k % 2) == 0) ? first_d : ~first_d;
      expect_ack(is_d, 1'b0, 1'b0, is_d, n + 1 + k);
    end
    repeat (20) step();
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    step(); bus.mem_ready = 1'b0;
    drain("t6_drain");
    chk("t6_d_count", d_seen - d0, 10);
    chk("t6_i_count", i_seen - i0, 10);
    #3 chk("t6_idle", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
